muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide, one iteration per cycle.
// Multiply uses shift-add on operand magnitudes. Divide uses restoring division on
// operand magnitudes. Signs are applied when the result is loaded into hi/lo.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  // Per-operation control captured at acceptance.
  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate product / quotient
    logic neg_r;   // negate remainder (sign of dividend)
    logic b_zero;  // divide by zero: quotient forced to all ones
  } ctl_t;

  state_t           state, state_nxt;
  ctl_t             ctl;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc, acc_nxt;       // upper product half / partial remainder
  logic [WIDTH-1:0] mq, mq_nxt;         // multiplier / dividend-then-quotient
  logic [WIDTH-1:0] bmag;               // multiplicand / divisor magnitude
  logic             accept, last;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shl, diff;
  logic             ge;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] q_fin, r_fin, hi_fin, lo_fin;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(WIDTH));

  // Signed ops work on magnitudes; a most-negative input's magnitude fits WIDTH bits unsigned.
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CALC;
      end
      CALC: if (last) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One multiply or divide iteration.
  always_comb begin
    sum     = '0;
    shl     = '0;
    diff    = '0;
    ge      = 1'b0;
    acc_nxt = acc;
    mq_nxt  = mq;
    if (ctl.is_div) begin
      shl     = {acc[WIDTH-1:0], mq[WIDTH-1]};
      diff    = shl - {1'b0, bmag};
      ge      = ~diff[WIDTH];
      acc_nxt = ge ? diff : shl;
      mq_nxt  = {mq[WIDTH-2:0], ge};
    end else begin
      sum     = acc + (mq[0] ? {1'b0, bmag} : {(WIDTH+1){1'b0}});
      acc_nxt = {1'b0, sum[WIDTH:1]};
      mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    end
  end

  // Sign fix-up and final hi/lo selection. When dividing by zero, every
  // trial subtract succeeds, so the remainder register ends up holding the
  // dividend magnitude. Re-signing it gives back a, as required.
  always_comb begin
    prod   = {acc[WIDTH-1:0], mq};
    prod_s = ctl.neg_q ? -prod : prod;
    q_fin  = ctl.b_zero ? {WIDTH{1'b1}} : (ctl.neg_q ? -mq : mq);
    r_fin  = ctl.neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    hi_fin = ctl.is_div ? r_fin : prod_s[2*WIDTH-1:WIDTH];
    lo_fin = ctl.is_div ? q_fin : prod_s[WIDTH-1:0];
  end

  // Datapath: capture on acceptance, iterate in CALC, and load hi/lo on the last CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      mq   <= '0;
      bmag <= '0;
      ctl  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (accept) begin
      cnt        <= '0;
      acc        <= '0;
      mq         <= a_mag;
      bmag       <= b_mag;
      ctl.is_div <= op[1];
      ctl.neg_q  <= a_neg ^ b_neg;
      ctl.neg_r  <= a_neg;
      ctl.b_zero <= op[1] & (b == '0);
    end else if (state == CALC) begin
      if (last) begin
        hi <= hi_fin;
        lo <= lo_fin;
      end else begin
        acc <= acc_nxt;
        mq  <= mq_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: fixed vectors, multi-cycle corner sequences, and random ops checked against an arithmetic model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a, b, eh, el;
  } vec_t;

  task automatic chk(input string name, input string what, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", name, what, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the operation definitions.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    logic [63:0] p;
    int sx, sy;
    longint px;
    sx = x; sy = y;
    h = '0; l = '0;
    case (o)
      2'd0: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
      2'd1: begin px = sx; p = px * longint'(sy); h = p[63:32]; l = p[31:0]; end
      2'd2: if (y == 0) begin h = x; l = '1; end else begin l = x / y; h = x % y; end
      default:
        if (y == 0) begin h = x; l = '1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = x; h = '0; end
        else begin l = sx / sy; h = sx % sy; end
    endcase
  endfunction

  // Expects start/op/a/b to be set up for the next edge. Waits for done and
  // checks latency, busy, stability of hi/lo while busy, and the result.
  task automatic collect(input string name, input bit hold, input logic [W-1:0] eh, input logic [W-1:0] el);
    logic [W-1:0] ph, pl;
    int n;
    bit got, stable, busy_ok;
    ph = hi; pl = lo; n = 0; got = 0; stable = 1; busy_ok = 1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    if (!busy) busy_ok = 0;
    while (n < 60 && !got) begin
      if (hold) begin a = $urandom; b = $urandom; end
      @(posedge clk); #1;
      n++;
      if (!busy) busy_ok = 0;
      if (done) got = 1;
      else if (hi !== ph || lo !== pl) stable = 0;
    end
    chk(name, "done_seen", 64'(got), 64'd1);
    chk(name, "latency", 64'(n), 64'(W + 1));
    chk(name, "busy", 64'(busy_ok), 64'd1);
    chk(name, "hold", 64'(stable), 64'd1);
    chk(name, "hi", 64'(hi), 64'(eh));
    chk(name, "lo", 64'(lo), 64'(el));
    @(posedge clk); #1;
    chk(name, "idle_busy", 64'(busy), 64'd0);
    chk(name, "idle_done", 64'(done), 64'd0);
    chk(name, "keep_lo", 64'(lo), 64'(el));
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] eh, el;
    bit saw;

    vecs.push_back('{"multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_neg3x5", 2'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{"div_neg7by2", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_by0", 2'd2, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000});
    vecs.push_back('{"divu_100by7", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14});
    vecs.push_back('{"multu_12x12", 2'd0, 32'd12, 32'd12, 32'd0, 32'd144});
    vecs.push_back('{"div_neg_by0", 2'd3, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{"mult_minsq", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0});
    vecs.push_back('{"div_7byneg2", 2'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD});
    vecs.push_back('{"div_min_by1", 2'd3, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000});
    vecs.push_back('{"mult_neg1x1", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});

    // Reset with a request already pending: it must be taken on the first edge after release.
    rst_n = 1'b0; start = 1'b1; op = 2'd0; a = '1; b = '1;
    repeat (3) @(negedge clk);
    chk("reset", "busy", 64'(busy), 64'd0);
    chk("reset", "done", 64'(done), 64'd0);
    chk("reset", "hi", 64'(hi), 64'd0);
    chk("reset", "lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    collect("first_edge", 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);

    // Fixed vectors; entries 5 and 6 run back to back.
    foreach (vecs[i]) begin
      @(negedge clk);
      start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      collect(vecs[i].name, 1'b0, vecs[i].eh, vecs[i].el);
    end

    // Keep start high and change operands while the first op is running.
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    collect("hold_start1", 1'b1, 32'd2, 32'd14);
    op = 2'd0; a = 32'd12; b = 32'd12;
    collect("hold_start2", 1'b0, 32'd0, 32'd144);

    // Assert reset partway through an operation.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFF; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset", "busy", 64'(busy), 64'd0);
    chk("mid_reset", "done", 64'(done), 64'd0);
    chk("mid_reset", "hi", 64'(hi), 64'd0);
    chk("mid_reset", "lo", 64'(lo), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1;
    end
    chk("mid_reset", "no_done", 64'(saw), 64'd0);

    // Random operations, with division and MIN/-1 corner values biased in.
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      start = 1'b1;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 15))
        0: b = '0;
        1: b = '1;
        2: a = 32'h8000_0000;
        3: begin a = 32'h8000_0000; b = '1; end
        4: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      model(op, a, b, eh, el);
      collect($sformatf("rand%0d_op%0d", i, op), 1'b0, eh, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
